arb_lock_n: RTL and testbench

//  N-way registered arbiter: fixed-priority (programmable top), round-robin and LFSR-random modes.

---
 rtl/arb_pkg.sv | 58 +++++
 rtl/arb_lock_n_if.sv | 28 ++
 rtl/arb_lfsr.sv | 18 +
 rtl/arb_lock_n.sv | 163 ++++++++++++++++
 tb/tb_arb_lock_n.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arb_lock_n arbiter: mode/state enums,
// circular first-set picker and maximal-length Galois LFSR tap masks.
package arb_pkg;

   localparam int unsigned MAX_N = 16;

   typedef enum logic [1:0] {
      ARB_FIXED = 2'd0,
      ARB_RR    = 2'd1,
      ARB_RAND  = 2'd2
   } arb_mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT  = 2'd1,
      LOCK = 2'd2
   } arb_state_e;

   // One-hot of the first set bit of mask searching start, start+1, ... (mod n).
   // Walking backwards lets the lowest offset overwrite earlier finds.
   function automatic logic [MAX_N-1:0] pick_from(input logic [3:0] start,
                                                  input logic [MAX_N-1:0] mask,
                                                  input logic [4:0] n);
      logic [MAX_N-1:0] res;
      logic [4:0]       idx;
      res = '0;
      for (int i = MAX_N - 1; i >= 0; i--) begin
         idx = {1'b0, start} + 5'(i);
         if (idx >= n) idx = idx - n;
         if ((5'(i) < n) && mask[idx[3:0]]) begin
            res = '0;
            res[idx[3:0]] = 1'b1;
         end
      end
      return res;
   endfunction

   // Right-shift Galois toggle masks for maximal-length sequences.
   function automatic logic [15:0] lfsr_taps(input int w);
      case (w)
         3:       return 16'h0006;
         4:       return 16'h000C;
         5:       return 16'h0014;
         6:       return 16'h0030;
         7:       return 16'h0060;
         8:       return 16'h00B8;
         9:       return 16'h0110;
         10:      return 16'h0240;
         11:      return 16'h0500;
         12:      return 16'h0E08;
         13:      return 16'h1C80;
         14:      return 16'h3802;
         15:      return 16'h6000;
         default: return 16'hD008;
      endcase
   endfunction

endpackage

// File: rtl/arb_lock_n_if.sv
// Requester/arbiter bundle for arb_lock_n. Handshake: req[i] is level-held by
// master i; gnt is a registered one-hot select, valid while gnt_vld is high.
interface arb_lock_n_if #(parameter int N = 4);
   import arb_pkg::*;

   localparam int IDW = $clog2(N);

   logic [N-1:0]   req;
   logic [N-1:0]   lock;
   logic [2:0]     arb_type;
   logic [IDW-1:0] prio_sel;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           gnt_vld;
   logic [N-1:0]   starve;
   arb_state_e     dbg_state;

   modport master (
      output req, lock, arb_type, prio_sel,
      input  gnt, gnt_id, gnt_vld, starve, dbg_state
   );

   modport slave (
      input  req, lock, arb_type, prio_sel,
      output gnt, gnt_id, gnt_vld, starve, dbg_state
   );

endinterface

// File: rtl/arb_lfsr.sv
// Galois PN generator seeded with 1; advances every cycle out of reset.
module arb_lfsr import arb_pkg::*; #(
   parameter int LFSR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [LFSR_W-1:0] out
);

   localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      out <= LFSR_W'(1);
      else if (out[0]) out <= (out >> 1) ^ TAPS;
      else             out <= out >> 1;
   end

endmodule

// File: rtl/arb_lock_n.sv
// N-way registered arbiter (fixed / round-robin / random) with bounded grant
// locking. Define ARB_STARVE_EN to add per-master starvation override.
module arb_lock_n import arb_pkg::*; #(
   parameter int N          = 4,
   parameter int LFSR_W     = 8,
   parameter int MAX_HOLD   = 8,
   parameter int STARVE_LIM = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   arb_lock_n_if.slave bus
);

   localparam int IDW = $clog2(N);
   localparam int HW  = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
   localparam logic [4:0]    N5       = 5'(N);

   arb_state_e        state_q, state_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic [HW-1:0]     hold_q, hold_d;
   logic [IDW-1:0]    rr_ptr_q;
   logic [IDW-1:0]    start_rr, start_rand;
   logic [LFSR_W-1:0] lfsr;
   logic [N-1:0]      starve_q, starve_pick;
   logic [N-1:0]      holder_lock, pick_all, pick_other;
   logic [3:0]        pick_start;
   logic              pick_circ;
   logic              mode_off;
   arb_mode_e         mode;

   arb_lfsr #(.LFSR_W(LFSR_W)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .out   (lfsr)
   );

   function automatic logic [IDW-1:0] oh2idx(input logic [N-1:0] oh);
      logic [IDW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) if (oh[i]) r = r | IDW'(i);
      return r;
   endfunction

   // Fixed and random try their start index first, then plain ascending;
   // round-robin is a true circular search.
   function automatic logic [N-1:0] mode_pick(input logic [N-1:0] mask,
                                              input logic [3:0] s,
                                              input logic circ);
      logic [MAX_N-1:0] m, res;
      m = MAX_N'(mask);
      if (circ) res = pick_from(s, m, N5);
      else if (m[s]) begin
         res    = '0;
         res[s] = 1'b1;
      end else res = pick_from(4'd0, m, N5);
      return N'(res);
   endfunction

   assign mode_off   = bus.arb_type > 3'd2;
   assign mode       = (bus.arb_type == 3'd1) ? ARB_RR :
                       (bus.arb_type == 3'd2) ? ARB_RAND : ARB_FIXED;
   assign start_rr   = (rr_ptr_q == IDW'(N - 1)) ? '0 : rr_ptr_q + IDW'(1);
   assign start_rand = IDW'(32'(lfsr) % 32'(N));

   always_comb begin
      pick_start = 4'd0;
      pick_circ  = 1'b0;
      case (mode)
         ARB_FIXED: pick_start = (5'(bus.prio_sel) < N5) ? 4'(bus.prio_sel) : 4'd0;
         ARB_RR: begin
            pick_start = 4'(start_rr);
            pick_circ  = 1'b1;
         end
         default:   pick_start = 4'(start_rand);
      endcase
   end

   assign holder_lock = gnt_q & bus.req & bus.lock;
   assign pick_all    = mode_pick(bus.req, pick_start, pick_circ);
   assign pick_other  = mode_pick(bus.req & ~gnt_q, pick_start, pick_circ);

   always_comb begin
      gnt_d   = '0;
      state_d = IDLE;
      hold_d  = '0;
      if (mode_off) begin
         gnt_d = '0;
      end else if (|starve_pick) begin
         gnt_d   = starve_pick;
         state_d = GNT;
         hold_d  = HW'(1);
      end else if ((|holder_lock) && (hold_q < HOLD_MAX)) begin
         gnt_d   = gnt_q;
         state_d = LOCK;
         hold_d  = hold_q + HW'(1);
      end else if (|holder_lock) begin
         // Hold expired: holder sits out one pick unless nobody else wants the bus.
         gnt_d   = (|pick_other) ? pick_other : gnt_q;
         state_d = GNT;
         hold_d  = HW'(1);
      end else if (|pick_all) begin
         gnt_d   = pick_all;
         state_d = GNT;
         hold_d  = HW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         gnt_q    <= '0;
         hold_q   <= '0;
         rr_ptr_q <= IDW'(N - 1);
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         hold_q  <= hold_d;
         if (|gnt_d) rr_ptr_q <= oh2idx(gnt_d);
      end
   end

`ifdef ARB_STARVE_EN
   localparam int CW = $clog2(STARVE_LIM + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

   logic [CW-1:0] wait_q [N];
   logic [CW-1:0] wait_d [N];

   always_comb begin
      for (int i = 0; i < N; i++) begin
         wait_d[i] = wait_q[i];
         if (!bus.req[i] || gnt_d[i]) wait_d[i] = '0;
         else if (wait_q[i] != LIM)   wait_d[i] = wait_q[i] + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) wait_q[i] <= '0;
         starve_q <= '0;
      end else begin
         for (int i = 0; i < N; i++) begin
            wait_q[i]   <= wait_d[i];
            starve_q[i] <= (wait_d[i] == LIM);
         end
      end
   end

   // A starved master that has since dropped req must not be granted.
   assign starve_pick = N'(pick_from(4'd0, MAX_N'(starve_q & bus.req), N5));
`else
   assign starve_q    = '0;
   assign starve_pick = '0;
`endif

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = oh2idx(gnt_q);
   assign bus.gnt_vld   = |gnt_q;
   assign bus.starve    = starve_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_arb_lock_n.sv
// Self-checking bench for arb_lock_n: directed scenarios plus randomized
// traffic scored against a priority-list reference model.
module tb_arb_lock_n;
   import arb_pkg::*;

   localparam int N          = 4;
   localparam int IDW        = $clog2(N);
   localparam int MAX_HOLD   = 8;
   localparam int STARVE_LIM = 16;

   logic clk;
   logic rst_n;

   arb_lock_n_if #(.N(N)) bus ();

   arb_lock_n #(
      .N          (N),
      .LFSR_W     (8),
      .MAX_HOLD   (MAX_HOLD),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   int n_chk  = 0;
   int n_fail = 0;
   logic [N-1:0] exp_q[$];

   int         m_gnt;
   int         m_held;
   int         m_last;
   int         m_lfsr;
   int         m_wait [N];
   logic [N-1:0] m_starve;
   arb_state_e m_state;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expected);
      n_chk++;
      if (got !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expected, $time);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_reset();
      m_gnt    = -1;
      m_held   = 0;
      m_last   = N - 1;
      m_lfsr   = 1;
      m_starve = '0;
      m_state  = IDLE;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      exp_q.delete();
   endtask

   // Build the candidate order for the mode, take the first requester not excluded.
   function automatic int model_pick(input int mode, input logic [N-1:0] r, input int prio, input int excl);
      int order[$];
      int s;
      if (mode == 1) begin
         for (int k = 1; k <= N; k++) order.push_back((m_last + k) % N);
      end else begin
         s = (mode == 0) ? prio : (m_lfsr % N);
         if (s < N) order.push_back(s);
         for (int i = 0; i < N; i++) if (i != s) order.push_back(i);
      end
      foreach (order[j]) if (r[order[j]] && order[j] != excl) return order[j];
      return -1;
   endfunction

   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] l, input int t, input int p);
      int nxt;
      logic [N-1:0] e;
      nxt = -1;
      if (t > 2) begin
         m_held  = 0;
         m_state = IDLE;
      end else begin
`ifdef ARB_STARVE_EN
         for (int i = N - 1; i >= 0; i--) if (m_starve[i] && r[i]) nxt = i;
`endif
         if (nxt >= 0) begin
            m_held  = 1;
            m_state = GNT;
         end else if (m_gnt >= 0 && r[m_gnt] && l[m_gnt]) begin
            if (m_held < MAX_HOLD) begin
               nxt     = m_gnt;
               m_held  = m_held + 1;
               m_state = LOCK;
            end else begin
               nxt = model_pick(t, r, p, m_gnt);
               if (nxt < 0) nxt = m_gnt;
               m_held  = 1;
               m_state = GNT;
            end
         end else begin
            nxt     = model_pick(t, r, p, -1);
            m_held  = (nxt >= 0) ? 1 : 0;
            m_state = (nxt >= 0) ? GNT : IDLE;
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!r[i] || nxt == i)         m_wait[i] = 0;
         else if (m_wait[i] < STARVE_LIM) m_wait[i] = m_wait[i] + 1;
`ifdef ARB_STARVE_EN
         m_starve[i] = (m_wait[i] == STARVE_LIM);
`endif
      end
      if (nxt >= 0) m_last = nxt;
      m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 'hB8) : (m_lfsr >> 1);
      m_gnt  = nxt;
      e = '0;
      if (nxt >= 0) e[nxt] = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic compare_outputs();
      logic [N-1:0] e;
      e = exp_q.pop_front();
      check_val("gnt",     32'(bus.gnt),       32'(e));
      check_val("gnt_vld", 32'(bus.gnt_vld),   32'(|e));
      check_val("gnt_id",  32'(bus.gnt_id),    (m_gnt >= 0) ? 32'(m_gnt) : 32'd0);
      check_val("starve",  32'(bus.starve),    32'(m_starve));
      check_val("state",   32'(bus.dbg_state), 32'(m_state));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_step(input logic [N-1:0] r, input logic [N-1:0] l,
                             input logic [2:0] t, input logic [IDW-1:0] p);
      bus.req      = r;
      bus.lock     = l;
      bus.arb_type = t;
      bus.prio_sel = p;
      @(posedge clk);
      model_step(r, l, int'(t), int'(p));
      #1;
      compare_outputs();
   endtask

   // Asserts reset wherever the caller is in the cycle; outputs must drop at once.
   task automatic apply_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      check_val("rst_gnt",     32'(bus.gnt),       32'd0);
      check_val("rst_gnt_id",  32'(bus.gnt_id),    32'd0);
      check_val("rst_gnt_vld", 32'(bus.gnt_vld),   32'd0);
      check_val("rst_starve",  32'(bus.starve),    32'd0);
      check_val("rst_state",   32'(bus.dbg_state), 32'(IDLE));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   int rand_cnt [N];
   logic [N-1:0]   r;
   logic [N-1:0]   l;
   logic [2:0]     t;
   logic [IDW-1:0] p;

   initial begin
      bus.req      = '0;
      bus.lock     = '0;
      bus.arb_type = '0;
      bus.prio_sel = '0;
      rst_n        = 1'b0;
      #2;
      apply_reset();

      // Fixed priority, top index 2.
      drive_step(4'b1011, 4'b0000, 3'd0, 2'd2);
      check_val("fixed_absent_top", 32'(bus.gnt), 32'b0001);
      drive_step(4'b0111, 4'b0000, 3'd0, 2'd2);
      check_val("fixed_top", 32'(bus.gnt), 32'b0100);

      // Round-robin rotation and pointer wrap.
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         drive_step(4'b1111, 4'b0000, 3'd1, 2'd0);
         check_val("rr_rotate", 32'(bus.gnt), 32'(1 << (k % 4)));
      end

      // Lock with bounded hold: 8 cycles held, one yield, relock.
      apply_reset();
      for (int k = 0; k < 10; k++) begin
         drive_step(4'b0011, 4'b0001, 3'd1, 2'd0);
         check_val("lock_expiry", 32'(bus.gnt), (k == 8) ? 32'b0010 : 32'b0001);
      end
      for (int k = 0; k < 20; k++) begin
         drive_step(4'b0001, 4'b0001, 3'd1, 2'd0);
         check_val("lock_alone", 32'(bus.gnt), 32'b0001);
      end

      // Random mode coverage.
      apply_reset();
      for (int i = 0; i < N; i++) rand_cnt[i] = 0;
      for (int k = 0; k < 64; k++) begin
         drive_step(4'b1111, 4'b0000, 3'd2, 2'd0);
         check_val("rand_onehot", 32'($onehot(bus.gnt)), 32'd1);
         for (int i = 0; i < N; i++) if (bus.gnt[i]) rand_cnt[i]++;
      end
      for (int i = 0; i < N; i++) check_val("rand_cover", 32'(rand_cnt[i] > 0), 32'd1);

      // Disabled mode overrides lock; reset mid-lock.
      apply_reset();
      for (int k = 0; k < 3; k++) drive_step(4'b0001, 4'b0001, 3'd1, 2'd0);
      drive_step(4'b0001, 4'b0001, 3'd5, 2'd0);
      check_val("disable_gnt", 32'(bus.gnt), 32'd0);
      for (int k = 0; k < 3; k++) drive_step(4'b0001, 4'b0001, 3'd0, 2'd0);
      check_val("pre_rst_lock", 32'(bus.dbg_state), 32'(LOCK));
      #2;
      apply_reset();
      drive_step(4'b0001, 4'b0000, 3'd0, 2'd0);
      check_val("post_rst_gnt", 32'(bus.gnt), 32'b0001);

      // Randomized traffic with sticky inputs so locks can run to expiry.
      apply_reset();
      r = 4'b1111;
      l = 4'b0001;
      t = 3'd0;
      p = 2'd0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 7) == 0) r = N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 7) == 0) l = N'($urandom_range(0, (1 << N) - 1));
         if ($urandom_range(0, 15) == 0)
            t = ($urandom_range(0, 9) > 7) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         if ($urandom_range(0, 15) == 0) p = IDW'($urandom_range(0, N - 1));
         drive_step(r, l, t, p);
         check_val("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
      end

      // Long wait of master 1 under fixed priority 0.
      apply_reset();
      for (int k = 0; k < 24; k++) begin
         drive_step(4'b0011, 4'b0000, 3'd0, 2'd0);
`ifdef ARB_STARVE_EN
         check_val("starve_gnt", 32'(bus.gnt), (k == 16) ? 32'b0010 : 32'b0001);
`else
         check_val("nostarve_gnt", 32'(bus.gnt), 32'b0001);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
